display_scheduler: RTL and testbench

//  Owns the 8-digit 7-segment driver: decides what it shows, and whether it is enabled.

---
 rtl/display_scheduler_if.sv | 23 ++
 rtl/display_scheduler.sv | 160 ++++++++++++++++
 tb/tb_display_scheduler.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/display_scheduler_if.sv
// Handshake and display bus between the temperature/cipher logic, the scheduler and the segment driver.
interface display_scheduler_if;
  logic        temp_valid;
  logic [31:0] temp_data;
  logic        msg_valid;
  logic [31:0] msg_data;
  logic        msg_blink;
  logic        msg_ready;
  logic        msg_done;
  logic        disp_en;
  logic [31:0] disp_data;
  logic        busy;

  modport master (
    output temp_valid, temp_data, msg_valid, msg_data, msg_blink,
    input  msg_ready, msg_done, disp_en, disp_data, busy
  );

  modport slave (
    input  temp_valid, temp_data, msg_valid, msg_data, msg_blink,
    output msg_ready, msg_done, disp_en, disp_data, busy
  );
endinterface

// File: rtl/display_scheduler.sv
// Chooses what the 8-digit display shows: latest temperature word, or a pre-empting
// message held for HOLD_MS ms ticks, optionally blinking at BLINK_MS half-period.
//
// state    | meaning
// ST_BLANK | no temperature seen yet, display off
// ST_TEMP  | showing the temperature shadow
// ST_MSG   | a message owns the display until its hold expires
module display_scheduler #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int HOLD_MS       = 2000,
  parameter int BLINK_MS      = 250
) (
  input  logic                clk,
  input  logic                rst_n,
  display_scheduler_if.slave  bus
);

  localparam int               TICK_DIV   = CLK_FREQUENCY / 1000;
  localparam logic [31:0]      TICK_LAST  = 32'(TICK_DIV - 1);
  localparam int               HW         = $clog2(HOLD_MS) + 1;
  localparam int               BW         = $clog2(BLINK_MS) + 1;
  localparam logic [HW-1:0]    HOLD_LAST  = HW'(HOLD_MS - 1);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_MS - 1);

  typedef enum logic [1:0] {ST_BLANK, ST_TEMP, ST_MSG} state_t;

  state_t        state, state_nxt;
  logic [31:0]   tick_cnt;
  logic          tick;
  logic [31:0]   temp_shadow, temp_nxt;
  logic          temp_seen, seen_nxt;
  logic [31:0]   msg_latch, msg_nxt;
  logic          blink_latch, blink_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [BW-1:0] blink_cnt, bcnt_nxt;
  logic          blink_phase, phase_nxt;
  logic          accept;

  logic          disp_en_q, disp_en_nxt;
  logic [31:0]   disp_data_q, disp_data_nxt;
  logic          msg_ready_q, ready_nxt;
  logic          busy_q, busy_nxt;
  logic          msg_done_q, done_nxt;

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running ms tick; only rst_n restarts it, so message holds are tick-quantised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BLANK;
      temp_shadow <= '0;
      temp_seen   <= 1'b0;
      msg_latch   <= '0;
      blink_latch <= 1'b0;
      hold_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      disp_en_q   <= 1'b0;
      disp_data_q <= '0;
      msg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      msg_done_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      temp_shadow <= temp_nxt;
      temp_seen   <= seen_nxt;
      msg_latch   <= msg_nxt;
      blink_latch <= blink_nxt;
      hold_cnt    <= hold_nxt;
      blink_cnt   <= bcnt_nxt;
      blink_phase <= phase_nxt;
      disp_en_q   <= disp_en_nxt;
      disp_data_q <= disp_data_nxt;
      msg_ready_q <= ready_nxt;
      busy_q      <= busy_nxt;
      msg_done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    temp_nxt      = temp_shadow;
    seen_nxt      = temp_seen;
    msg_nxt       = msg_latch;
    blink_nxt     = blink_latch;
    hold_nxt      = hold_cnt;
    bcnt_nxt      = blink_cnt;
    phase_nxt     = blink_phase;
    done_nxt      = 1'b0;
    disp_en_nxt   = 1'b0;
    disp_data_nxt = '0;
    accept        = bus.msg_valid & msg_ready_q;

    if (bus.temp_valid) begin
      temp_nxt = bus.temp_data;
      seen_nxt = 1'b1;
    end

    case (state)
      ST_BLANK: if (bus.temp_valid) state_nxt = ST_TEMP;
      ST_TEMP:  state_nxt = ST_TEMP;
      ST_MSG: begin
        if (tick) begin
          hold_nxt = hold_cnt + 1'b1;
          if (blink_cnt == BLINK_LAST) begin
            bcnt_nxt  = '0;
            phase_nxt = ~blink_phase;
          end else begin
            bcnt_nxt = blink_cnt + 1'b1;
          end
          if (hold_cnt == HOLD_LAST) begin
            done_nxt  = 1'b1;
            state_nxt = seen_nxt ? ST_TEMP : ST_BLANK;
          end
        end
      end
      default: state_nxt = ST_BLANK;
    endcase

    // msg_ready is low throughout ST_MSG, so accept only fires from BLANK/TEMP or the exit cycle.
    if (accept) begin
      msg_nxt   = bus.msg_data;
      blink_nxt = bus.msg_blink;
      hold_nxt  = '0;
      bcnt_nxt  = '0;
      phase_nxt = 1'b1;
      state_nxt = ST_MSG;
    end

    case (state_nxt)
      ST_TEMP: begin
        disp_en_nxt   = 1'b1;
        disp_data_nxt = temp_nxt;
      end
      ST_MSG: begin
        disp_en_nxt   = blink_nxt ? phase_nxt : 1'b1;
        disp_data_nxt = msg_nxt;
      end
      default: begin
        disp_en_nxt   = 1'b0;
        disp_data_nxt = '0;
      end
    endcase

    ready_nxt = (state_nxt != ST_MSG);
    busy_nxt  = (state_nxt == ST_MSG);
  end

  assign bus.disp_en   = disp_en_q;
  assign bus.disp_data = disp_data_q;
  assign bus.msg_ready = msg_ready_q;
  assign bus.busy      = busy_q;
  assign bus.msg_done  = msg_done_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: 10 clk per ms tick, 4-tick hold, 1-tick blink.
module tb_display_scheduler;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   ecnt;

  display_scheduler_if bus();

  display_scheduler #(
    .CLK_FREQUENCY(10_000),
    .HOLD_MS      (4),
    .BLINK_MS     (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges seen since reset release; the ms tick is active in cycles where ecnt % 10 == 9.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.disp_en !== 1'b0 || bus.disp_data !== 32'h0 || bus.msg_ready !== 1'b0 ||
        bus.busy !== 1'b0 || bus.msg_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b data=%h ready=%b busy=%b done=%b, expected all 0",
               bus.disp_en, bus.disp_data, bus.msg_ready, bus.busy, bus.msg_done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (bus.disp_en !== 1'b0 || bus.disp_data !== 32'h0 || bus.msg_ready !== 1'b1 ||
          bus.busy !== 1'b0 || bus.msg_done !== 1'b0) begin
        errors++;
        $display("FAIL blank_idle cyc%0d: got en=%b data=%h ready=%b busy=%b done=%b, expected en=0 data=0 ready=1 busy=0 done=0",
                 i, bus.disp_en, bus.disp_data, bus.msg_ready, bus.busy, bus.msg_done);
      end
    end
  endtask

  task automatic test_temp(input logic [31:0] t);
    bus.temp_valid = 1'b1;
    bus.temp_data  = t;
    step();
    bus.temp_valid = 1'b0;
    checks++;
    if (bus.disp_en !== 1'b1 || bus.disp_data !== t || bus.msg_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL temp_show: got en=%b data=%h ready=%b busy=%b, expected en=1 data=%h ready=1 busy=0",
               bus.disp_en, bus.disp_data, bus.msg_ready, bus.busy, t);
    end
  endtask

  task automatic accept_msg(input logic [31:0] d, input logic blink);
    bus.msg_valid = 1'b1;
    bus.msg_data  = d;
    bus.msg_blink = blink;
    step();
    bus.msg_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.msg_ready !== 1'b0 || bus.disp_data !== d ||
        bus.disp_en !== 1'b1 || bus.msg_done !== 1'b0) begin
      errors++;
      $display("FAIL accept: got busy=%b ready=%b data=%h en=%b done=%b, expected busy=1 ready=0 data=%h en=1 done=0",
               bus.busy, bus.msg_ready, bus.disp_data, bus.disp_en, bus.msg_done, d);
    end
  endtask

  // Starts in the first MSG cycle; returns observing the msg_done cycle.
  task automatic hold_msg(input logic [31:0] d, input logic blink, input logic [31:0] rdata,
                          input logic ren, input logic do_mid, input logic [31:0] mid);
    int   n;
    int   it;
    logic exp_en;
    n  = 0;
    it = 0;
    while (n < 4 && it < 100) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.msg_done !== 1'b0 || bus.msg_ready !== 1'b0 || bus.disp_data !== d) begin
        errors++;
        $display("FAIL hold_state t%0d: got busy=%b done=%b ready=%b data=%h, expected busy=1 done=0 ready=0 data=%h",
                 n, bus.busy, bus.msg_done, bus.msg_ready, bus.disp_data, d);
      end
      exp_en = blink ? ((n % 2) == 0) : 1'b1;
      checks++;
      if (bus.disp_en !== exp_en) begin
        errors++;
        $display("FAIL hold_en t%0d: got %b expected %b", n, bus.disp_en, exp_en);
      end
      if (ecnt % 10 == 9) n++;
      if (do_mid && it == 2) begin
        bus.temp_valid = 1'b1;
        bus.temp_data  = mid;
      end else if (do_mid && it == 3) begin
        bus.temp_valid = 1'b0;
      end
      step();
      it++;
    end
    checks++;
    if (n < 4) begin
      errors++;
      $display("FAIL hold_timeout: got %0d ticks expected 4", n);
    end
    checks++;
    if (bus.msg_done !== 1'b1 || bus.busy !== 1'b0 || bus.msg_ready !== 1'b1 ||
        bus.disp_data !== rdata || bus.disp_en !== ren) begin
      errors++;
      $display("FAIL msg_exit: got done=%b busy=%b ready=%b data=%h en=%b, expected done=1 busy=0 ready=1 data=%h en=%b",
               bus.msg_done, bus.busy, bus.msg_ready, bus.disp_data, bus.disp_en, rdata, ren);
    end
  endtask

  task automatic after_exit(input logic [31:0] rdata, input logic ren);
    step();
    checks++;
    if (bus.msg_done !== 1'b0 || bus.disp_data !== rdata || bus.disp_en !== ren || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_exit: got done=%b data=%h en=%b busy=%b, expected done=0 data=%h en=%b busy=0",
               bus.msg_done, bus.disp_data, bus.disp_en, bus.busy, rdata, ren);
    end
  endtask

  task automatic test_msg_plain();
    accept_msg(32'hC0DE_0001, 1'b0);
    hold_msg(32'hC0DE_0001, 1'b0, 32'h0000_0235, 1'b1, 1'b0, 32'h0);
    after_exit(32'h0000_0235, 1'b1);
  endtask

  task automatic test_msg_blink();
    accept_msg(32'hC0DE_0001, 1'b1);
    hold_msg(32'hC0DE_0001, 1'b1, 32'h0000_0235, 1'b1, 1'b0, 32'h0);
    after_exit(32'h0000_0235, 1'b1);
  endtask

  task automatic test_temp_during_msg();
    accept_msg(32'hC0DE_0003, 1'b0);
    hold_msg(32'hC0DE_0003, 1'b0, 32'h0000_0240, 1'b1, 1'b1, 32'h0000_0240);
    after_exit(32'h0000_0240, 1'b1);
  endtask

  task automatic test_back_to_back();
    accept_msg(32'hAAAA_0001, 1'b0);
    bus.msg_valid = 1'b1;
    bus.msg_data  = 32'hBBBB_0002;
    bus.msg_blink = 1'b0;
    hold_msg(32'hAAAA_0001, 1'b0, 32'h0000_0240, 1'b1, 1'b0, 32'h0);
    step();
    bus.msg_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.msg_ready !== 1'b0 || bus.disp_data !== 32'hBBBB_0002 || bus.msg_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b ready=%b data=%h done=%b, expected busy=1 ready=0 data=bbbb0002 done=0",
               bus.busy, bus.msg_ready, bus.disp_data, bus.msg_done);
    end
    hold_msg(32'hBBBB_0002, 1'b0, 32'h0000_0240, 1'b1, 1'b0, 32'h0);
    after_exit(32'h0000_0240, 1'b1);
  endtask

  task automatic test_temp_with_accept();
    bus.temp_valid = 1'b1;
    bus.temp_data  = 32'h0000_0250;
    accept_msg(32'hFACE_0004, 1'b0);
    bus.temp_valid = 1'b0;
    hold_msg(32'hFACE_0004, 1'b0, 32'h0000_0250, 1'b1, 1'b0, 32'h0);
    after_exit(32'h0000_0250, 1'b1);
  endtask

  task automatic test_reset_mid_msg();
    accept_msg(32'hDEAD_BEEF, 1'b0);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.disp_en !== 1'b0 || bus.disp_data !== 32'h0 || bus.msg_ready !== 1'b0 ||
        bus.busy !== 1'b0 || bus.msg_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_msg: got en=%b data=%h ready=%b busy=%b done=%b, expected all 0",
               bus.disp_en, bus.disp_data, bus.msg_ready, bus.busy, bus.msg_done);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      checks++;
      if (bus.msg_done !== 1'b0 || bus.msg_ready !== 1'b1 || bus.busy !== 1'b0 ||
          bus.disp_en !== 1'b0 || bus.disp_data !== 32'h0) begin
        errors++;
        $display("FAIL after_reset cyc%0d: got done=%b ready=%b busy=%b en=%b data=%h, expected done=0 ready=1 busy=0 en=0 data=0",
                 i, bus.msg_done, bus.msg_ready, bus.busy, bus.disp_en, bus.disp_data);
      end
    end
  endtask

  task automatic test_msg_from_blank();
    accept_msg(32'h1234_5678, 1'b1);
    hold_msg(32'h1234_5678, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    after_exit(32'h0, 1'b0);
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    rst_n          = 1'b0;
    bus.temp_valid = 1'b0;
    bus.temp_data  = 32'h0;
    bus.msg_valid  = 1'b0;
    bus.msg_data   = 32'h0;
    bus.msg_blink  = 1'b0;

    test_reset();
    test_temp(32'h0000_0235);
    test_msg_plain();
    repeat (3) step();
    test_msg_blink();
    repeat (7) step();
    test_temp_during_msg();
    test_back_to_back();
    repeat (2) step();
    test_temp_with_accept();
    test_reset_mid_msg();
    test_msg_from_blank();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
